// File: rtl/b01_serial_fsm.sv
// ITC'99 b01 serial-input state machine: two serial streams drive an 8-state FSM
// with registered result (outp) and overflow (overflw) bits.
module b01_serial_fsm (
  input  logic clock,
  input  logic reset,
  input  logic line1,
  input  logic line2,
  input  logic __obs,
  output logic outp,
  output logic overflw
);

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_C   = 3'd2,
    S_E   = 3'd3,
    S_F   = 3'd4,
    S_G   = 3'd5,
    S_WF0 = 3'd6,
    S_WF1 = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   outp_d;
  logic   overflw_d;

  logic bit_xor;
  logic bit_and;
  logic bit_or;

  // The observation hook has no functional role; it is tied off here.
  logic unused_obs;
  assign unused_obs = __obs;

  assign bit_xor = line1 ^ line2;
  assign bit_and = line1 & line2;
  assign bit_or  = line1 | line2;

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
      outp    <= 1'b0;
      overflw <= 1'b0;
    end else begin
      state_q <= state_d;
      outp    <= outp_d;
      overflw <= overflw_d;
    end
  end

  // Next-state and next-output selection.
  always_comb begin
    state_d   = S_A;
    outp_d    = 1'b0;
    overflw_d = 1'b0;
    case (state_q)
      S_A: begin
        state_d = bit_and ? S_F : S_B;
        outp_d  = bit_xor;
      end
      S_E: begin
        state_d   = bit_and ? S_F : S_B;
        outp_d    = bit_xor;
        overflw_d = 1'b1;
      end
      S_B: begin
        state_d = bit_and ? S_G : S_C;
        outp_d  = ~bit_xor;
      end
      S_F: begin
        state_d = bit_or ? S_G : S_C;
        outp_d  = ~bit_xor;
      end
      S_C: begin
        state_d = bit_and ? S_WF1 : S_WF0;
        outp_d  = bit_xor;
      end
      S_G: begin
        state_d = bit_or ? S_WF1 : S_WF0;
        outp_d  = ~bit_xor;
      end
      S_WF0: begin
        state_d = bit_and ? S_E : S_A;
        outp_d  = bit_xor;
      end
      S_WF1: begin
        state_d = bit_or ? S_E : S_A;
        outp_d  = ~bit_xor;
      end
      default: begin
        state_d   = S_A;
        outp_d    = 1'b0;
        overflw_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_b01_serial_fsm.sv
// Directed bench for b01_serial_fsm: hand-computed output sequences per scenario.
module tb_b01_serial_fsm;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic line1 = 1'b0;
  logic line2 = 1'b0;
  logic obs   = 1'b0;
  logic outp;
  logic overflw;

  int total = 0;
  int bad   = 0;
  bit obs_en = 1'b0;

  logic ones_outp [9];
  logic ones_ovf  [9];

  b01_serial_fsm dut (
    .clock   (clock),
    .reset   (reset),
    .line1   (line1),
    .line2   (line2),
    .__obs   (obs),
    .outp    (outp),
    .overflw (overflw)
  );

  always #5 clock = ~clock;

  // Random activity on the observation hook when enabled.
  always #3 if (obs_en) obs = 1'($urandom);

  // Drive one input pair, let one rising edge take it, sample 1ns later.
  task automatic step(input logic l1, input logic l2);
    line1 = l1;
    line2 = l2;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    line1 = 1'($urandom);
    line2 = 1'($urandom);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (outp !== 1'b0 || overflw !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: outp=%b overflw=%b required 0 0", outp, overflw);
    end
    for (int i = 0; i < 3; i++) begin
      line1 = 1'b1;
      line2 = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if (outp !== 1'b0 || overflw !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: outp=%b overflw=%b required 0 0", i, outp, overflw);
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_all_zero();
    logic exp_o [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      total++;
      if (outp !== exp_o[i % 4] || overflw !== 1'b0) begin
        bad++;
        $display("FAIL all_zero[%0d]: outp=%b overflw=%b required %b 0", i, outp, overflw, exp_o[i % 4]);
      end
    end
  endtask

  task automatic test_all_ones();
    logic exp_o [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_v [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1);
      ones_outp[i] = outp;
      ones_ovf[i]  = overflw;
      total++;
      if (outp !== exp_o[i] || overflw !== exp_v[i]) begin
        bad++;
        $display("FAIL all_ones[%0d]: outp=%b overflw=%b required %b %b", i, outp, overflw, exp_o[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_mixed();
    logic [1:0] ins [4] = '{2'b11, 2'b00, 2'b10, 2'b00};
    logic exp_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(ins[i][1], ins[i][0]);
      total++;
      if (outp !== exp_o[i] || overflw !== 1'b0) begin
        bad++;
        $display("FAIL mixed[%0d]: outp=%b overflw=%b required %b 0", i, outp, overflw, exp_o[i]);
      end
    end
    // Confirm the machine is back in A: 00 from A goes to B with outp 0.
    step(1'b0, 1'b0);
    total++;
    if (outp !== 1'b0 || overflw !== 1'b0) begin
      bad++;
      $display("FAIL mixed_tail: outp=%b overflw=%b required 0 0", outp, overflw);
    end
  endtask

  // Every transition arm, including the and/or distinctions in F, G, WF1, B, C, WF0.
  task automatic test_transitions();
    logic [1:0] ins [17] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10,
                             2'b00, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
    logic exp_o [17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_v [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      step(ins[i][1], ins[i][0]);
      total++;
      if (outp !== exp_o[i] || overflw !== exp_v[i]) begin
        bad++;
        $display("FAIL transitions[%0d]: outp=%b overflw=%b required %b %b", i, outp, overflw, exp_o[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int n = 4; n <= 5; n++) begin
      apply_reset();
      for (int i = 0; i < n; i++) step(1'b1, 1'b1);
      // After 4 edges: in E with outp=1; after 5 edges: in F with overflw=1.
      total++;
      if (outp !== (n == 4) || overflw !== (n == 5)) begin
        bad++;
        $display("FAIL mid_reset_pre[%0d]: outp=%b overflw=%b required %b %b", n, outp, overflw, n == 4, n == 5);
      end
      reset = 1'b1;
      #1;
      total++;
      if (outp !== 1'b0 || overflw !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_async[%0d]: outp=%b overflw=%b required 0 0", n, outp, overflw);
      end
      #1;
      reset = 1'b0;
      step(1'b1, 1'b1);
      total++;
      if (outp !== 1'b0 || overflw !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_a_to_f[%0d]: outp=%b overflw=%b required 0 0", n, outp, overflw);
      end
      step(1'b1, 1'b1);
      total++;
      if (outp !== 1'b1 || overflw !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_f_to_g[%0d]: outp=%b overflw=%b required 1 0", n, outp, overflw);
      end
    end
  endtask

  task automatic test_obs();
    logic exp_o [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_v [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    obs_en = 1'b1;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1);
      total++;
      if (outp !== exp_o[i] || overflw !== exp_v[i]) begin
        bad++;
        $display("FAIL obs_expected[%0d]: outp=%b overflw=%b required %b %b", i, outp, overflw, exp_o[i], exp_v[i]);
      end
      total++;
      if (outp !== ones_outp[i] || overflw !== ones_ovf[i]) begin
        bad++;
        $display("FAIL obs_vs_quiet[%0d]: outp=%b overflw=%b required %b %b", i, outp, overflw, ones_outp[i], ones_ovf[i]);
      end
    end
    obs_en = 1'b0;
    obs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_ones();
    test_mixed();
    test_transitions();
    test_mid_reset();
    test_obs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b01_serial_fsm.md
# b01_serial_fsm

Serial-input finite state machine: the module `b01`, an ITC'99-style benchmark core. It samples two serial bit streams (`line1`, `line2`) on every rising clock edge and advances an 8-state machine. Each edge also produces a registered result bit `outp` and a registered overflow flag `overflw`. The block is a self-contained leaf driven directly by a stimulus harness.

## Interface
- No parameters.
- `clock`  input  1  rising-edge clock; all state and outputs update on it.
- `reset`  input  1  asynchronous, active-high; forces state and outputs to reset values immediately.
- `line1`  input  1  serial data stream 1, sampled at the rising edge.
- `line2`  input  1  serial data stream 2, sampled at the rising edge.
- `__obs`  input  1  observation/tooling hook; functionally ignored, with no effect on state or outputs.
- `outp`  output  1  registered result bit.
- `overflw`  output  1  registered overflow flag.

## Operation
- Internal 3-bit state register with these encodings: A=0, B=1, C=2, E=3, F=4, G=5, WF0=6, WF1=7.
- Let `x = line1 ^ line2`, `and = line1 & line2`, `or = line1 | line2`.
- On each rising edge with `reset` low, the current state selects the next state and the new output values:
  - A: next = and ? F : B; outp <= x; overflw <= 0.
  - E: next = and ? F : B; outp <= x; overflw <= 1.
  - B: next = and ? G : C; outp <= ~x; overflw <= 0.
  - F: next = or ? G : C; outp <= ~x; overflw <= 0.
  - C: next = and ? WF1 : WF0; outp <= x; overflw <= 0.
  - G: next = or ? WF1 : WF0; outp <= ~x; overflw <= 0.
  - WF0: next = and ? E : A; outp <= x; overflw <= 0.
  - WF1: next = or ? E : A; outp <= ~x; overflw <= 0.
- `overflw` is 1 for exactly the cycle following an edge taken while in state E.
- All 8 encodings are legal, so there is no illegal-state recovery path. A default branch maps to A with outputs 0.
- Inputs are used only at clock edges. The block has no combinational path from any input to any output.

## Timing
- Reset (async, active-high): state = A, outp = 0, overflw = 0, all taking effect without a clock edge. While `reset` is high, clock edges have no effect.
- Reset deassertion: the first rising edge after deassertion evaluates state A with the inputs present at that edge.
- Latency: outputs and next state are registered one edge after input sampling.
- Reset asserted mid-sequence: state and outputs return to A/0/0 immediately and the stream restarts from A.
- `__obs` toggling at any time: no observable effect.

## Test plan
- Reset check: assert `reset` with inputs random -> outp=0, overflw=0 immediately, before any clock edge.
- All-zero stream: after reset, line1=line2=0 every edge -> states A→B→C→WF0→A. outp per edge = 0,1,0,0, repeating. overflw stays 0.
- All-ones stream: line1=line2=1 every edge -> A→F→G→WF1→E→F… outp = 0,1,1,1, then 0,1,1,1. overflw = 0,0,0,0,1,0,0,0,1… (1 on the 5th, 9th, … edges).
- Mixed sequence: from reset, (l1,l2) = 11,00,10,00 -> states F,C,WF0,A. outp = 0,1,1,0. overflw all 0.
- Mid-run reset: drive all-ones until E is reached, then pulse `reset` asynchronously between edges -> overflw and outp drop to 0 at once. The next all-ones edge goes A→F with outp=0.
- Observation independence: repeat the all-ones scenario while toggling `__obs` randomly -> outputs are identical to the run with `__obs` held constant.
